// File: rtl/fixed_32_div_if.sv
// Handshake and data bundle for the sequential Q24.8 divider.
// The master side supplies operands and accepts results; the slave side is the divider.
interface fixed_32_div_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] q_out;
    logic        overflow;
    logic        underflow_q;
    logic        div_by_zero;

    modport master (
        output in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, q_out, overflow, underflow_q, div_by_zero
    );

    modport slave (
        input  in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, q_out, overflow, underflow_q, div_by_zero
    );
endinterface

// File: rtl/fixed_32_div.sv
// Sequential signed Q24.8 restoring divider: q = (a << FRACT_BITS) / b, one quotient bit per cycle.
// Define FIXED_DIV_SATURATE_EN to clamp q_out on overflow/underflow instead of wrapping.
module fixed_32_div #(
    parameter int FRACT_BITS = 8
) (
    input  logic           clk,
    input  logic           rst,
    fixed_32_div_if.slave  bus
);

    localparam int ITER  = 32 + FRACT_BITS;
    localparam int CNT_W = $clog2(ITER + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);
    localparam logic [ITER-1:0]  POS_MAX   = ITER'(32'h7FFF_FFFF);
    localparam logic [ITER-1:0]  NEG_MAX   = ITER'(32'h8000_0000);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic              sign_q, sign_d;
    logic [31:0]       b_mag_q, b_mag_d;
    logic [ITER-1:0]   num_q, num_d;
    logic [31:0]       rem_q, rem_d;
    logic [ITER-1:0]   quo_q, quo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       result_q, result_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              dbz_q, dbz_d;

    logic [31:0]       a_mag;
    logic [31:0]       b_mag;
    logic [32:0]       rem_shift;
    logic              rem_ge;
    logic              fix_neg;
    logic              fix_ovf;
    logic              fix_unf;
    logic [31:0]       fix_low;

    // Magnitudes are unsigned, so the most negative operand maps cleanly to 2^31.
    assign a_mag = bus.a_in[31] ? (32'd0 - bus.a_in) : bus.a_in;
    assign b_mag = bus.b_in[31] ? (32'd0 - bus.b_in) : bus.b_in;

    // The remainder stays below |b| <= 2^31, so only the shifted trial value needs a 33rd bit.
    assign rem_shift = {rem_q, num_q[ITER-1]};
    assign rem_ge    = (rem_shift >= {1'b0, b_mag_q});

    assign fix_neg = sign_q && (quo_q != '0);
    assign fix_ovf = !fix_neg && (quo_q > POS_MAX);
    assign fix_unf = fix_neg && (quo_q > NEG_MAX);
    assign fix_low = fix_neg ? (32'd0 - quo_q[31:0]) : quo_q[31:0];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            b_mag_q  <= '0;
            num_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            b_mag_q  <= b_mag_d;
            num_q    <= num_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            dbz_q    <= dbz_d;
        end
    end

    always_comb begin
        // NOTE: every next-state value defaults to its register so no branch can infer a latch.
        state_d  = state_q;
        sign_d   = sign_q;
        b_mag_d  = b_mag_q;
        num_d    = num_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        dbz_d    = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_d  = bus.a_in[31] ^ bus.b_in[31];
                    b_mag_d = b_mag;
                    num_d   = {a_mag, {FRACT_BITS{1'b0}}};
                    rem_d   = '0;
                    quo_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    if (bus.b_in == 32'd0) begin
                        dbz_d    = 1'b1;
                        result_d = bus.a_in[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                        state_d  = DONE;
                    end else begin
                        dbz_d   = 1'b0;
                        state_d = CALC;
                    end
                end
            end

            CALC: begin
                num_d = num_q << 1;
                rem_d = rem_ge ? (rem_shift[31:0] - b_mag_q) : rem_shift[31:0];
                quo_d = {quo_q[ITER-2:0], rem_ge};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = FIX;
                end
            end

            FIX: begin
                ovf_d = fix_ovf;
                unf_d = fix_unf;
`ifdef FIXED_DIV_SATURATE_EN
                if (fix_ovf) begin
                    result_d = 32'h7FFF_FFFF;
                end else if (fix_unf) begin
                    result_d = 32'h8000_0000;
                end else begin
                    result_d = fix_low;
                end
`else
                result_d = fix_low;
`endif
                state_d = DONE;
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.q_out       = result_q;
    assign bus.overflow    = ovf_q;
    assign bus.underflow_q = unf_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_fixed_32_div.sv
// Directed bench for fixed_32_div: vector table plus backpressure and mid-calculation reset sequences.
// Expected results follow FIXED_DIV_SATURATE_EN the same way the design does.
module tb_fixed_32_div;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   lat;
    logic busy_ready;

    fixed_32_div_if bus ();

    fixed_32_div dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef FIXED_DIV_SATURATE_EN
    localparam logic [31:0] OVF_Q = 32'h7FFF_FFFF;
    localparam logic [31:0] UNF_Q = 32'h8000_0000;
`else
    localparam logic [31:0] OVF_Q = 32'h8000_0000;
    localparam logic [31:0] UNF_Q = 32'h0000_0000;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic        ovf;
        logic        unf;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present one operand pair, then scramble the inputs and wait (bounded) for out_valid.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a_in     = a;
        bus.b_in     = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a_in     = 32'hDEAD_BEEF;
        bus.b_in     = 32'h1234_5678;
        busy_ready   = bus.in_ready;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        bus.in_valid  = 1'b0;
        bus.a_in      = '0;
        bus.b_in      = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;

        vecs[0]  = '{32'h0000_0300, 32'h0000_0200, 32'h0000_0180, 1'b0, 1'b0, 1'b0, 42};
        vecs[1]  = '{32'hFFFF_F880, 32'h0000_0280, 32'hFFFF_FD00, 1'b0, 1'b0, 1'b0, 42};
        vecs[2]  = '{32'hFFFF_FF00, 32'h0000_0300, 32'hFFFF_FFAB, 1'b0, 1'b0, 1'b0, 42};
        vecs[3]  = '{32'h4000_0000, 32'h0000_0080, OVF_Q,         1'b1, 1'b0, 1'b0, 42};
        vecs[4]  = '{32'h8000_0000, 32'h0000_0080, UNF_Q,         1'b0, 1'b1, 1'b0, 42};
        vecs[5]  = '{32'hC000_0000, 32'h0000_0080, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 42};
        vecs[6]  = '{32'h0000_0100, 32'h0000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1};
        vecs[7]  = '{32'hFFFF_FF00, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1};
        vecs[8]  = '{32'h0000_0100, 32'hFFFF_FF00, 32'hFFFF_FF00, 1'b0, 1'b0, 1'b0, 42};
        vecs[9]  = '{32'h0001_0000, 32'h0000_0001, 32'h0100_0000, 1'b0, 1'b0, 1'b0, 42};
        vecs[10] = '{32'h0000_0100, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 42};
        vecs[11] = '{32'h0000_0000, 32'hFFFF_FE00, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 42};
        vecs[12] = '{32'h7FFF_FFFF, 32'h0000_0100, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 42};
        vecs[13] = '{32'h8000_0000, 32'h0000_0100, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 42};
        vecs[14] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 42};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_in_ready",  64'(bus.in_ready),  64'd1);
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_q_out",     64'(bus.q_out),     64'd0);
        check("reset_flags", {61'd0, bus.overflow, bus.underflow_q, bus.div_by_zero}, 64'd0);

        // out_ready is already high, so each result is taken on its first DONE cycle.
        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].a, vecs[i].b);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("v%0d_q_out", i), 64'(bus.q_out), 64'(vecs[i].q));
            check($sformatf("v%0d_flags", i),
                  {61'd0, bus.overflow, bus.underflow_q, bus.div_by_zero},
                  {61'd0, vecs[i].ovf, vecs[i].unf, vecs[i].dbz});
            @(posedge clk);
            #1;
            check($sformatf("v%0d_consumed", i), {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
        end

        // Backpressure: the result must hold steady while out_ready is low.
        bus.out_ready = 1'b0;
        run_op(32'h0000_0300, 32'h0000_0200);
        check("bp_busy_in_ready", 64'(busy_ready), 64'd0);
        check("bp_latency", 64'(lat), 64'd42);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp_hold_%0d", c),
                  {27'd0, bus.out_valid, bus.in_ready, bus.overflow, bus.underflow_q,
                   bus.div_by_zero, bus.q_out},
                  {27'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0180});
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release", {62'd0, bus.out_valid, bus.in_ready}, 64'd1);

        // Reset during CALC: outputs clear asynchronously and a fresh operation still works.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a_in     = 32'hFFFF_F880;
        bus.b_in     = 32'h0000_0280;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_mid_q_out",     64'(bus.q_out),     64'd0);
        check("rst_mid_flags", {61'd0, bus.overflow, bus.underflow_q, bus.div_by_zero}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
        run_op(32'hFFFF_FF00, 32'h0000_0300);
        check("post_rst_latency", 64'(lat), 64'd42);
        check("post_rst_q_out", 64'(bus.q_out), 64'hFFFF_FFAB);
        check("post_rst_flags", {61'd0, bus.overflow, bus.underflow_q, bus.div_by_zero}, 64'd0);
        @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
